// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the MIPS pipeline front end.
//               Defines the fetch FSM state type and the IF/ID entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Width of one instruction word in bytes; the PC advances by this amount.
  localparam int unsigned INSTR_BYTES = 4;

  // Fetch sequencer states. WAIT holds the single outstanding memory read;
  // DISCARD swallows the response of a read made obsolete by a redirect.
  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // One buffered instruction, laid out exactly like the IF/ID buffer:
  // pc_plus4 occupies the upper 32 bits, the instruction word the lower 32.
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary (instruction fetches are aligned).
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(32'(INSTR_BYTES) - 32'd1);
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Small circular FIFO of fetched instructions with a registered
//               head entry, synchronous flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

  fetch_entry_t      r_mem [DEPTH];
  fetch_entry_t      r_head;
  fetch_entry_t      w_head_next;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  w_rd_next;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_do_push;
  logic              w_do_pop;

  // A flush wins over everything else in the same cycle. A push into a full
  // queue is only legal when a pop frees a slot in that same cycle.
  assign w_do_pop  = pop && !flush && (r_count != '0);
  assign w_do_push = push && !flush && ((r_count < c_depth) || w_do_pop);
  assign w_rd_next = r_rd_ptr + c_ptr_one;

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    w_count_next = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_next = r_count + c_cnt_one;
    end else if (w_do_pop && !w_do_push) begin
      w_count_next = r_count - c_cnt_one;
    end
  end

  // Next head: the entry behind the popped one, or the incoming word when the
  // queue is (or becomes) otherwise empty. Stalled heads stay put.
  always_comb begin
    w_head_next = r_head;
    if (w_do_pop) begin
      if (r_count == c_cnt_one) begin
        if (w_do_push) begin
          w_head_next = din;
        end
      end else begin
        w_head_next = r_mem[w_rd_next];
      end
    end else if (w_do_push && (r_count == '0)) begin
      w_head_next = din;
    end
  end

  // Pointer, count and head registers; pointers wrap naturally (power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      r_count <= w_count_next;
      r_head  <= w_head_next;
    end
  end

  // Entry storage; contents are only ever read once the count covers them.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  assign dout  = r_head;
  assign count = r_count;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch front end of the 5-stage MIPS pipeline.
//               Owns the PC, issues one word read at a time, queues returned
//               instructions for IF/ID and squashes wrong-path work on branch
//               redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus4
);

  localparam int unsigned      CNT_W        = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] c_depth      = CNT_W'(QUEUE_DEPTH);
  localparam logic [31:0]      c_instr_step = 32'(INSTR_BYTES);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [31:0]       r_pc;
  logic [31:0]       r_req_pc;
  logic [CNT_W-1:0]  w_count;
  logic              w_space;
  logic              w_req;
  logic              w_push;
  logic              w_pop;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  // A request is only made when a slot is free; since pops never take space
  // away, the response is guaranteed to fit when it returns.
  assign w_space = (w_count < c_depth);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a redirect overrides normal sequencing in every state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      REQ: begin
        if (!redirect && w_space) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          // The outstanding read is now wrong-path; drop it on arrival unless
          // it is arriving right now, in which case it is already dropped.
          w_state_next = imem_valid ? REQ : DISCARD;
        end else if (imem_valid) begin
          w_state_next = REQ;
        end
      end
      DISCARD: begin
        if (imem_valid) begin
          w_state_next = REQ;
        end
      end
      default: w_state_next = REQ;
    endcase
  end

  // Output decode: memory request strobe and queue push strobe.
  always_comb begin
    w_req  = (r_state == REQ) && w_space && !redirect && !rst;
    w_push = (r_state == WAIT) && imem_valid && !redirect;
  end

  // PC and request-address tracking; a redirect target is word-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else if (redirect) begin
      r_pc <= word_align(redirect_target);
    end else if (w_req) begin
      r_req_pc <= r_pc;
      r_pc     <= r_pc + c_instr_step;
    end
  end

  // A handshake coinciding with a redirect is squashed along with the queue.
  assign w_pop = out_valid && out_ready && !redirect;

  assign w_push_entry.pc_plus4 = r_req_pc + c_instr_step;
  assign w_push_entry.instr    = imem_rdata;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .din   (w_push_entry),
    .dout  (w_head),
    .count (w_count)
  );

  assign imem_req     = w_req;
  assign imem_addr    = r_pc;
  assign out_valid    = (w_count != '0);
  assign out_instr    = w_head.instr;
  assign out_pc_plus4 = w_head.pc_plus4;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed scenarios plus a
//               randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
  import pipe_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_stage #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_valid      (imem_valid),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc_plus4    (out_pc_plus4)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: two fixed words, hashed pattern elsewhere.
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h2002000A;
    if (a == 32'h4) return 32'h00432020;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Behavioural memory: captures a request mid-cycle, answers after a latency.
  logic        mem_en   = 1'b0;
  logic        mem_rand = 1'b0;
  int          mem_lat  = 1;
  logic        rsp_pend = 1'b0;
  logic [31:0] rsp_addr = '0;
  int          rsp_cnt  = 0;

  always @(negedge clk) begin
    if (mem_en && imem_req) begin
      rsp_pend = 1'b1;
      rsp_addr = imem_addr;
      rsp_cnt  = mem_rand ? int'($urandom_range(3, 1)) : mem_lat;
    end
  end

  always @(posedge clk) begin
    #1;
    if (mem_en) begin
      imem_valid = 1'b0;
      if (rsp_pend) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = memword(rsp_addr);
          rsp_pend   = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reset for two cycles; returns at the drive point of the first free cycle.
  task automatic do_reset();
    rst        = 1'b1;
    redirect   = 1'b0;
    out_ready  = 1'b0;
    imem_valid = 1'b0;
    rsp_pend   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Wait (bounded) for the queue head to become valid.
  task automatic wait_ov(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, imem_req, imem_addr, out_pc_plus4, out_instr} !== {2'b00, RESET_PC, 64'h0})
      $display("FAIL reset_state: got v=%b req=%b addr=%h pc4=%h instr=%h want all zero, addr=%h",
               out_valid, imem_req, imem_addr, out_pc_plus4, out_instr, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic        er [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ea [5] = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h8};
    logic [64:0] eh [5] = '{65'h0, 65'h0, {1'b1, 32'h4, 32'h2002000A},
                            65'h0, {1'b1, 32'h8, 32'h00432020}};
    mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 1;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req !== er[k] || (er[k] && imem_addr !== ea[k]))
        $display("FAIL basic_req c%0d: got req=%b addr=%h want req=%b addr=%h",
                 k, imem_req, imem_addr, er[k], ea[k]);
      else n_pass++;
      n_checks++;
      if ((eh[k][64] && {out_valid, out_pc_plus4, out_instr} !== eh[k]) ||
          (!eh[k][64] && out_valid !== 1'b0))
        $display("FAIL basic_out c%0d: got v=%b pc4=%h instr=%h want %h",
                 k, out_valid, out_pc_plus4, out_instr, eh[k]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    int n_req = 0;
    mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 1;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imem_req) n_req++;
    end
    n_checks++;
    if (n_req !== 2) $display("FAIL stall_reqs: got %0d requests want 2", n_req);
    else n_pass++;
    n_checks++;
    if ({out_valid, out_pc_plus4, out_instr} !== {1'b1, 32'h4, 32'h2002000A})
      $display("FAIL stall_head: got v=%b pc4=%h instr=%h want 1/4/2002000a",
               out_valid, out_pc_plus4, out_instr);
    else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({imem_req, out_valid, out_pc_plus4, out_instr} !== {2'b01, 32'h4, 32'h2002000A})
      $display("FAIL stall_pop0: got req=%b v=%b pc4=%h instr=%h want 0/1/4/2002000a",
               imem_req, out_valid, out_pc_plus4, out_instr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({imem_req, imem_addr, out_valid, out_pc_plus4, out_instr} !==
        {1'b1, 32'h8, 1'b1, 32'h8, 32'h00432020})
      $display("FAIL stall_pop1: got req=%b addr=%h v=%b pc4=%h instr=%h want 1/8/1/8/00432020",
               imem_req, imem_addr, out_valid, out_pc_plus4, out_instr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL stall_empty: got v=%b want 0", out_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_pc_plus4, out_instr} !== {1'b1, 32'hC, memword(32'h8)})
      $display("FAIL stall_next: got v=%b pc4=%h instr=%h want 1/c/%h",
               out_valid, out_pc_plus4, out_instr, memword(32'h8));
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    int  n = 0;
    bit  seen = 1'b0;
    bit  ov_seen = 1'b0;
    bit  ok;
    mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 3;
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);                          // request to 0 goes out
    @(posedge clk); #1;
    redirect = 1'b1; redirect_target = 32'h0000_0031;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL rw_req_in_redirect: got %b want 0", imem_req);
    else n_pass++;
    @(posedge clk); #1;
    redirect = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (out_valid) ov_seen = 1'b1;
      if (imem_req) seen = 1'b1;
    end
    n_checks++;
    if (!seen || n !== 3 || imem_addr !== 32'h30)
      $display("FAIL rw_next_req: got seen=%b after %0d cycles addr=%h want 3 cycles addr=00000030",
               seen, n, imem_addr);
    else n_pass++;
    n_checks++;
    if (ov_seen) $display("FAIL rw_stale_queued: got out_valid=1 want 0 while discarding");
    else n_pass++;
    wait_ov(10, ok);
    n_checks++;
    if (!ok || {out_pc_plus4, out_instr} !== {32'h34, memword(32'h30)})
      $display("FAIL rw_new_head: got ok=%b pc4=%h instr=%h want 34/%h",
               ok, out_pc_plus4, out_instr, memword(32'h30));
    else n_pass++;
  endtask

  task automatic test_redirect_valid();
    bit ok;
    mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 1;
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;                      // response arrives this cycle
    redirect = 1'b1; redirect_target = 32'h0000_0100;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL rv_req_in_redirect: got %b want 0", imem_req);
    else n_pass++;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({imem_req, imem_addr, out_valid} !== {1'b1, 32'h100, 1'b0})
      $display("FAIL rv_next: got req=%b addr=%h v=%b want 1/00000100/0",
               imem_req, imem_addr, out_valid);
    else n_pass++;
    wait_ov(6, ok);
    n_checks++;
    if (!ok || {out_pc_plus4, out_instr} !== {32'h104, memword(32'h100)})
      $display("FAIL rv_head: got ok=%b pc4=%h instr=%h want 104/%h",
               ok, out_pc_plus4, out_instr, memword(32'h100));
    else n_pass++;
  endtask

  task automatic test_redirect_pop();
    bit ok;
    mem_en = 1'b1; mem_rand = 1'b0; mem_lat = 1;
    do_reset();
    repeat (8) @(negedge clk);               // queue fills to two entries
    @(posedge clk); #1;
    out_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0200;
    @(negedge clk);
    n_checks++;
    if ({out_valid, imem_req} !== 2'b10)
      $display("FAIL rp_during: got v=%b req=%b want 1/0", out_valid, imem_req);
    else n_pass++;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, imem_req, imem_addr} !== {2'b01, 32'h200})
      $display("FAIL rp_flushed: got v=%b req=%b addr=%h want 0/1/00000200",
               out_valid, imem_req, imem_addr);
    else n_pass++;
    wait_ov(6, ok);
    n_checks++;
    if (!ok || {out_pc_plus4, out_instr} !== {32'h204, memword(32'h200)})
      $display("FAIL rp_head: got ok=%b pc4=%h instr=%h want 204/%h",
               ok, out_pc_plus4, out_instr, memword(32'h200));
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    mem_en = 1'b0;
    do_reset();
    @(negedge clk);
    @(posedge clk); #1;
    imem_valid = 1'b1; imem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_pc_plus4, out_instr, imem_req, imem_addr} !==
        {1'b1, 32'h4, 32'h1111_1111, 1'b1, 32'h4})
      $display("FAIL rmw_setup: got v=%b pc4=%h instr=%h req=%b addr=%h want 1/4/11111111/1/4",
               out_valid, out_pc_plus4, out_instr, imem_req, imem_addr);
    else n_pass++;
    @(posedge clk); #1;                      // DUT now waiting on address 4
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, imem_req, imem_addr, out_pc_plus4, out_instr} !== {2'b00, RESET_PC, 64'h0})
      $display("FAIL rmw_async: got v=%b req=%b addr=%h pc4=%h instr=%h want 0/0/%h/0/0",
               out_valid, imem_req, imem_addr, out_pc_plus4, out_instr, RESET_PC);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;   // stale response
    @(negedge clk);
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, RESET_PC})
      $display("FAIL rmw_first_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
    else n_pass++;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rmw_stale: got v=%b want 0", out_valid);
    else n_pass++;
    @(posedge clk); #1;
    imem_valid = 1'b1; imem_rdata = 32'h2222_2222;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_pc_plus4, out_instr} !== {1'b1, RESET_PC + 32'h4, 32'h2222_2222})
      $display("FAIL rmw_fresh: got v=%b pc4=%h instr=%h want 1/%h/22222222",
               out_valid, out_pc_plus4, out_instr, RESET_PC + 32'h4);
    else n_pass++;
  endtask

  // Reference model: requests walk sequential word addresses from the latest
  // redirect target; a response is kept only if no redirect has happened
  // since its request; the queue is FIFO-ordered and emptied by redirects.
  task automatic test_random();
    fetch_entry_t mq[$];
    logic [31:0]  exp_req  = RESET_PC;
    logic [31:0]  req_addr = '0;
    bit           outst    = 1'b0;
    bit           acc;
    int           ep = 0, req_ep = 0, pops = 0;
    mem_en = 1'b1; mem_rand = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      out_ready = (($urandom % 4) != 0);
      redirect  = (($urandom % 20) == 0);
      redirect_target = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      @(negedge clk);
      if (redirect) begin
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL rnd_req_on_redirect c%0d: got 1 want 0", c);
        else n_pass++;
      end
      if (imem_req) begin
        n_checks++;
        if (outst) $display("FAIL rnd_outstanding c%0d: got second request want one outstanding", c);
        else n_pass++;
        n_checks++;
        if (imem_addr !== exp_req)
          $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_addr, exp_req);
        else n_pass++;
      end
      n_checks++;
      if (out_valid !== (mq.size() != 0))
        $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, mq.size() != 0);
      else n_pass++;
      if (out_valid && mq.size() != 0) begin
        n_checks++;
        if ({out_pc_plus4, out_instr} !== mq[0])
          $display("FAIL rnd_head c%0d: got %h/%h want %h", c, out_pc_plus4, out_instr, mq[0]);
        else n_pass++;
      end
      acc = 1'b0;
      if (imem_valid) begin
        acc   = outst && (req_ep == ep) && !redirect;
        outst = 1'b0;
      end
      if (redirect) begin
        mq.delete();
        exp_req = redirect_target & ~32'h3;
        ep++;
      end else if (out_valid && out_ready && mq.size() != 0) begin
        void'(mq.pop_front());
        pops++;
      end
      if (acc) mq.push_back({req_addr + 32'h4, memword(req_addr)});
      if (imem_req) begin
        outst    = 1'b1;
        req_addr = exp_req;
        req_ep   = ep;
        exp_req  = exp_req + 32'h4;
      end
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    n_checks++;
    if (pops < 100) $display("FAIL rnd_progress: got %0d handshakes want at least 100", pops);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_valid();
    test_redirect_pop();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage MIPS pipeline.
- Owns the PC and issues word reads to the byte-addressed instruction memory.
- Buffers returned instructions with their PC+4 in a small queue that feeds the IF/ID buffer through a valid/ready handshake.
- Accepts branch redirects from the EX/MEM branch decision (branch AND zero flag selecting the branch target) and flushes wrong-path work.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QUEUE_DEPTH, 2, number of instruction entries buffered (power of two, ≥2).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- imem_req  out  1  one-cycle read request pulse.
- imem_addr  out  32  byte address of the word requested; valid while imem_req=1.
- imem_rdata  in  32  instruction word, big-endian assembled from bytes addr..addr+3.
- imem_valid  in  1  one-cycle pulse returning the data for the single outstanding request; arrives ≥1 cycle after imem_req.
- redirect  in  1  branch taken; load redirect_target.
- redirect_target  in  32  new fetch address.
- out_valid  out  1  queue head valid.
- out_ready  in  1  IF/ID accepts the head this cycle (0 = stall).
- out_instr  out  32  head instruction.
- out_pc_plus4  out  32  head instruction address + 4.

Behaviour:
- Reset (asynchronous, any state): pc=RESET_PC, state=REQ, queue empty, out_valid=0, imem_req=0, out_instr=0, out_pc_plus4=0. Any in-flight memory response arriving after reset is ignored because the state is REQ, not WAIT.
- State machine states are REQ, WAIT and DISCARD. At most one request is outstanding at any time.
- REQ state:
  - imem_req = space && !redirect, where space = (count < QUEUE_DEPTH).
  - imem_addr = pc.
  - On a request: latch req_pc=pc, pc <= pc+4, go to WAIT.
  - Without a request, stay in REQ.
- WAIT state:
  - On imem_valid: push {pc_plus4=req_pc+4, instr=imem_rdata} and go to REQ. Throughput is at most one instruction per 2 cycles.
  - Space is guaranteed, because a request is issued only when space exists and pops never reduce it.
- DISCARD state: drop the next imem_valid without pushing it, then go to REQ.
- Redirect (highest priority, any state):
  - Queue is flushed.
  - pc <= {redirect_target[31:2],2'b00}.
  - Next state: WAIT goes to DISCARD, unless imem_valid is also asserted this cycle, in which case the response is dropped and the state goes to REQ. REQ goes to REQ with no request issued this cycle. DISCARD stays in DISCARD unless imem_valid is asserted this cycle, in which case it goes to REQ.
  - A pop in the same cycle is ignored.
  - out_valid=0 the following cycle.
- Queue:
  - Circular buffer with registered head. out_valid = (count!=0).
  - A pop occurs on out_valid && out_ready. Outputs are held stable while out_valid && !out_ready.
  - A push and a pop in the same cycle leave count unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- Arithmetic: 32-bit unsigned, pc+4 wraps 32'hFFFF_FFFC→0.
- Latency: reset release → imem_req in the first cycle; data valid in cycle N → out_valid in cycle N+1.

Decomposition:
- Shared package pipe_pkg:
  - constant INSTR_BYTES=4.
  - typedef fetch_state_t {REQ, WAIT, DISCARD}.
  - typedef fetch_entry_t {pc_plus4[31:0], instr[31:0]}, 64 bits, matching the IF/ID buffer layout with pc_plus4 in the upper half.
- One sub-module, fetch_queue: parameterised FIFO with clk, rst, push, pop, flush, din, dout, count.

Test Plan:
- Reset then out_ready=1, memory with latency 1, words 0x2002000A at addr 0 and 0x00432020 at addr 4 → imem_addr 0, then 4, then 8. Output {0x4,0x2002000A}, then {0x8,0x00432020}, each one cycle after its imem_valid.
- out_ready=0 with memory latency 1 → exactly 2 entries queued, no further imem_req. Raise out_ready → entries pop in order and the next imem_req uses addr 8.
- Redirect to 0x0000_0031 while in WAIT, data returns 2 cycles later → response dropped, next imem_addr=0x30, queue empty.
- Redirect and imem_valid in the same cycle → no push, next cycle imem_req with the target address.
- Redirect in the same cycle as an output handshake with 2 entries queued → both entries flushed, out_valid=0 next cycle.
- Assert rst mid-WAIT, then deliver imem_valid after release → outputs zero immediately, imem_addr=RESET_PC, stale data not queued.
